// File: rtl/riscvibe_pkg.sv
// ----------------------------------------------------------------------------
// riscvibe_pkg
// Shared definitions for the data-memory responder:
//   dmem_state_e  - request/response FSM states
//   MEM_*         - RV32I funct3 load/store width codes
//   access_size() - byte count of an access, 0 for an illegal width code
// ----------------------------------------------------------------------------
package riscvibe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    function automatic logic [2:0] access_size(input logic [2:0] width);
        logic [2:0] size;
        case (width)
            MEM_B, MEM_BU: size = 3'd1;
            MEM_H, MEM_HU: size = 3'd2;
            MEM_W:         size = 3'd4;
            default:       size = 3'd0;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// ----------------------------------------------------------------------------
// mem_lane_align
// Combinational byte-lane steering between an LSB-aligned 32-bit value and a
// little-endian 32-bit storage word.
//   byte_off_i [1:0]  byte offset of the access inside the word
//   width_i    [2:0]  funct3 width/sign code
//   wdata_i    [31:0] store data, LSB-aligned
//   rword_i    [31:0] storage word currently addressed
//   wword_o    [31:0] store data replicated onto every lane
//   be_o       [3:0]  byte enables of the addressed lanes
//   rdata_o    [31:0] load data, shifted down and sign/zero-extended
// ----------------------------------------------------------------------------
module mem_lane_align
    import riscvibe_pkg::*;
(
    input  logic [1:0]  byte_off_i,
    input  logic [2:0]  width_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [31:0] wword_o,
    output logic [3:0]  be_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    assign shifted = rword_i >> {byte_off_i, 3'b000};

    always_comb begin
        wword_o = wdata_i;
        be_o    = 4'b1111;
        rdata_o = rword_i;
        case (width_i)
            MEM_B, MEM_BU: begin
                // Replicating the data onto all lanes lets the byte enable
                // alone pick the destination lane.
                wword_o = {4{wdata_i[7:0]}};
                be_o    = 4'b0001 << byte_off_i;
                rdata_o = (width_i == MEM_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                             : {24'h0, shifted[7:0]};
            end
            MEM_H, MEM_HU: begin
                wword_o = {2{wdata_i[15:0]}};
                be_o    = byte_off_i[1] ? 4'b1100 : 4'b0011;
                rdata_o = (width_i == MEM_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                             : {16'h0, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// ----------------------------------------------------------------------------
// dmem_responder
// Single-outstanding data-memory responder with a fixed, programmable wait.
// Parameters: DEPTH (bytes, power of two), LATENCY (extra wait cycles, 0..15)
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready  request handshake (ready only in IDLE)
//   req_addr/we/width/wdata  byte address, store flag, funct3, store data
//   rsp_valid/rsp_ready  response handshake (valid only in RESP)
//   rsp_rdata            extended load data (0 for stores and errors)
//   rsp_err              misaligned, out-of-range or illegal width
// ----------------------------------------------------------------------------
module dmem_responder
    import riscvibe_pkg::*;
#(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_we,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH);

    dmem_state_e state_q;
    logic [3:0]  cnt_q;
    logic        req_ready_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] addr_q;
    logic        we_q;
    logic [2:0]  width_q;
    logic [31:0] wdata_q;

    logic [31:0] mem_q [DEPTH/4];

    logic [2:0]  size;
    logic [32:0] end_addr;
    logic        err_d;
    logic [31:0] rdata_d;
    logic        commit;
    logic        mem_we;
    logic [AW-3:0] widx;
    logic [31:0] rword;
    logic [31:0] wword;
    logic [3:0]  be;
    logic [31:0] ld_data;
    logic        accept;

    assign accept   = (state_q == ST_IDLE) && req_valid && req_ready_q;

    // Error decode on the latched request; stores only allow signed codes.
    assign size     = access_size(width_q);
    assign end_addr = {1'b0, addr_q} + {30'h0, size};
    assign err_d    = (size == 3'd0)
                   || (we_q && width_q[2])
                   || ((size == 3'd2) && addr_q[0])
                   || ((size == 3'd4) && (addr_q[1:0] != 2'b00))
                   || (end_addr > 33'(DEPTH));

    assign commit   = (state_q == ST_WAIT) && (cnt_q == 4'd0);
    assign mem_we   = commit && we_q && !err_d;
    assign widx     = addr_q[AW-1:2];
    assign rword    = mem_q[widx];
    assign rdata_d  = (we_q || err_d) ? 32'h0 : ld_data;

    mem_lane_align u_align (
        .byte_off_i (addr_q[1:0]),
        .width_i    (width_q),
        .wdata_i    (wdata_q),
        .rword_i    (rword),
        .wword_o    (wword),
        .be_o       (be),
        .rdata_o    (ld_data)
    );

    // Request fields are plain data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_addr;
            we_q    <= req_we;
            width_q <= req_width;
            wdata_q <= req_wdata;
        end
    end

    // Storage is not reset; a store only lands on the WAIT->RESP edge, so a
    // reset during WAIT drops it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem_q[widx][8*b +: 8] <= wword[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    req_ready_q <= 1'b1;
                    if (accept) begin
                        state_q     <= ST_WAIT;
                        cnt_q       <= 4'(LATENCY);
                        req_ready_q <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= err_d;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Ready rises with the return to IDLE, so the handshake
                    // cycle itself can never accept a new request.
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= 32'h0;
                        rsp_err_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    import riscvibe_pkg::*;

    localparam int DEPTH   = 4096;
    localparam int LATENCY = 1;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_we;
    logic [2:0]  req_width;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_width (req_width),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Called at 1ns after a rising edge; returns at the same phase.
    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) chk({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    endtask

    task automatic drive_req(input logic we, input logic [2:0] w,
                             input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        req_we    = we;
        req_width = w;
        req_addr  = a;
        req_wdata = d;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Counts rising edges after accept until rsp_valid is seen.
    task automatic wait_rsp(output int lat);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic txn(input string tag, input logic we, input logic [2:0] w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        wait_ready(tag);
        drive_req(we, w, a, d);
        wait_rsp(lat);
        chk({tag, "_lat"}, 32'(lat), 32'd2);
        if (!rsp_valid) return;
        chk({tag, "_rdata"}, rsp_rdata, exp_rd);
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_ready_in_resp"}, 32'(req_ready), 32'd0);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        int lat;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_width = MEM_W;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        rsp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        chk("rst_rsp_err",   32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_req_ready", 32'(req_ready), 32'd1);

        // Word store/load with latency check
        txn("sw20",  1'b1, MEM_W,  32'h20, 32'h12345678, 32'h0,        1'b0);
        txn("lw20",  1'b0, MEM_W,  32'h20, 32'h0,        32'h12345678, 1'b0);

        // Byte store touches only lane 1 -> word 0x12348078
        txn("sb21",  1'b1, MEM_B,  32'h21, 32'hABCDEF80, 32'h0,        1'b0);
        txn("lb21",  1'b0, MEM_B,  32'h21, 32'h0,        32'hFFFFFF80, 1'b0);
        txn("lbu21", 1'b0, MEM_BU, 32'h21, 32'h0,        32'h00000080, 1'b0);
        txn("lh20",  1'b0, MEM_H,  32'h20, 32'h0,        32'hFFFF8078, 1'b0);
        txn("lhu22", 1'b0, MEM_HU, 32'h22, 32'h0,        32'h00001234, 1'b0);

        // Upper half store -> word 0xC0DE8078
        txn("sh22",  1'b1, MEM_H,  32'h22, 32'h5555C0DE, 32'h0,        1'b0);
        txn("lw20b", 1'b0, MEM_W,  32'h20, 32'h0,        32'hC0DE8078, 1'b0);

        // Error cases leave storage untouched
        txn("lw22_mis",  1'b0, MEM_W,  32'h22, 32'h0,        32'h0, 1'b1);
        txn("lh23_mis",  1'b0, MEM_H,  32'h23, 32'h0,        32'h0, 1'b1);
        txn("w011",      1'b0, 3'b011, 32'h20, 32'h0,        32'h0, 1'b1);
        txn("sw22_mis",  1'b1, MEM_W,  32'h22, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("sbu_ill",   1'b1, MEM_BU, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
        txn("lw20c",     1'b0, MEM_W,  32'h20, 32'h0, 32'hC0DE8078, 1'b0);

        // Range boundary; 0x1000 would alias word 0 if not blocked
        txn("sw0",       1'b1, MEM_W,  32'h0,   32'h11111111, 32'h0, 1'b0);
        txn("sw_top",    1'b1, MEM_W,  32'hFFC, 32'hCAFEF00D, 32'h0, 1'b0);
        txn("lw_top",    1'b0, MEM_W,  32'hFFC, 32'h0, 32'hCAFEF00D, 1'b0);
        txn("lhu_ffe",   1'b0, MEM_HU, 32'hFFE, 32'h0, 32'h0000CAFE, 1'b0);
        txn("sw_oor",    1'b1, MEM_W,  32'h1000, 32'h99999999, 32'h0, 1'b1);
        txn("lw_oor",    1'b0, MEM_W,  32'h1000, 32'h0, 32'h0, 1'b1);
        txn("lw0",       1'b0, MEM_W,  32'h0,   32'h0, 32'h11111111, 1'b0);

        // Backpressure: response held, new requests ignored
        wait_ready("hold");
        drive_req(1'b0, MEM_W, 32'h20, 32'h0);
        wait_rsp(lat);
        chk("hold_lat", 32'(lat), 32'd2);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_width = MEM_W;
        req_addr  = 32'h20;
        req_wdata = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk($sformatf("hold%0d_valid", i), 32'(rsp_valid), 32'd1);
            chk($sformatf("hold%0d_rdata", i), rsp_rdata, 32'hC0DE8078);
            chk($sformatf("hold%0d_ready", i), 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        txn("lw20_after_hold", 1'b0, MEM_W, 32'h20, 32'h0, 32'hC0DE8078, 1'b0);

        // Reset during WAIT discards a pending store
        txn("sw10", 1'b1, MEM_W, 32'h10, 32'h55AA55AA, 32'h0, 1'b0);
        wait_ready("rstwait");
        drive_req(1'b1, MEM_W, 32'h10, 32'hDEADBEEF);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("rstwait_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("rstwait_valid2", 32'(rsp_valid), 32'd0);
        chk("rstwait_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        txn("lw10", 1'b0, MEM_W, 32'h10, 32'h0, 32'h55AA55AA, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
